// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares the single AXI4 read port of the window RAM between two read
// requesters. Requester 0 is the UART debug reader and requester 1 is a
// second on-chip reader. The arbiter grants whole bursts with round-robin
// fairness. It forwards the granted requester's AR channel to the RAM and
// steers R beats back to that requester until rlast. It never issues a new
// AR while the RAM reports reset-busy. It also checks each burst's beat
// count against the arlen that was issued.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   rsta_busy, rstb_busy     RAM reset-busy flags, gate IDLE -> ADDR
//   m0_ar*, m1_ar*           requester AR channels (fields, arvalid/arready)
//   m0_r*, m1_r*             requester R channels (data, rvalid/rready)
//   s_axi_ar*                RAM-side AR channel
//   s_axi_r*                 RAM-side R channel
//   grant                    one-hot owner, 00 when idle
//   busy                     high while in ADDR or DATA
//   len_err                  one-cycle pulse after a beat-count mismatch
// ----------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int unsigned DATA_BIT_WIDTH = 256,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rsta_busy,
    input  logic                      rstb_busy,

    // Requester 0
    input  logic [ID_WIDTH-1:0]       m0_arid,
    input  logic [ADDR_WIDTH-1:0]     m0_araddr,
    input  logic [7:0]                m0_arlen,
    input  logic [2:0]                m0_arsize,
    input  logic [1:0]                m0_arburst,
    input  logic                      m0_arvalid,
    output logic                      m0_arready,
    output logic [ID_WIDTH-1:0]       m0_rid,
    output logic [DATA_BIT_WIDTH-1:0] m0_rdata,
    output logic [1:0]                m0_rresp,
    output logic                      m0_rlast,
    output logic                      m0_rvalid,
    input  logic                      m0_rready,

    // Requester 1
    input  logic [ID_WIDTH-1:0]       m1_arid,
    input  logic [ADDR_WIDTH-1:0]     m1_araddr,
    input  logic [7:0]                m1_arlen,
    input  logic [2:0]                m1_arsize,
    input  logic [1:0]                m1_arburst,
    input  logic                      m1_arvalid,
    output logic                      m1_arready,
    output logic [ID_WIDTH-1:0]       m1_rid,
    output logic [DATA_BIT_WIDTH-1:0] m1_rdata,
    output logic [1:0]                m1_rresp,
    output logic                      m1_rlast,
    output logic                      m1_rvalid,
    input  logic                      m1_rready,

    // RAM side
    output logic [ID_WIDTH-1:0]       s_axi_arid,
    output logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    output logic [7:0]                s_axi_arlen,
    output logic [2:0]                s_axi_arsize,
    output logic [1:0]                s_axi_arburst,
    output logic                      s_axi_arvalid,
    input  logic                      s_axi_arready,
    input  logic [ID_WIDTH-1:0]       s_axi_rid,
    input  logic [DATA_BIT_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]                s_axi_rresp,
    input  logic                      s_axi_rlast,
    input  logic                      s_axi_rvalid,
    output logic                      s_axi_rready,

    // Status
    output logic [1:0]                grant,
    output logic                      busy,
    output logic                      len_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_d;
    logic [1:0] r_grant;
    logic [1:0] w_grant_d;
    // Index of the requester that completed the most recent burst.
    logic       r_last_grant;
    logic       w_last_grant_d;
    logic [8:0] r_beat_cnt;
    logic [8:0] w_beat_cnt_d;
    logic       r_len_err;
    logic       w_len_err_d;

    logic       w_ram_busy;
    logic       w_any_req;
    logic       w_pick_m1;
    logic       w_ar_hs;
    logic       w_r_hs;

    assign w_ram_busy = rsta_busy | rstb_busy;
    assign w_any_req  = m0_arvalid | m1_arvalid;

    // If both requesters are asking, the one that did not own the previous
    // burst wins. Otherwise the single active requester wins.
    assign w_pick_m1  = (m0_arvalid & m1_arvalid) ? ~r_last_grant : m1_arvalid;

    assign w_ar_hs    = (r_state == ST_ADDR) & s_axi_arvalid & s_axi_arready;
    assign w_r_hs     = (r_state == ST_DATA) & s_axi_rvalid & s_axi_rready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_grant_d = r_last_grant;
        w_beat_cnt_d   = r_beat_cnt;
        w_len_err_d    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_d = 2'b00;
                if (!w_ram_busy && w_any_req) begin
                    w_grant_d = w_pick_m1 ? 2'b10 : 2'b01;
                    w_state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (w_ar_hs) begin
                    // s_axi_arlen already carries the granted requester's arlen.
                    w_beat_cnt_d = {1'b0, s_axi_arlen};
                    w_state_d    = ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_r_hs) begin
                    if (s_axi_rlast) begin
                        w_len_err_d    = (r_beat_cnt != 9'd0);
                        w_last_grant_d = r_grant[1];
                        w_grant_d      = 2'b00;
                        w_state_d      = ST_IDLE;
                    end else begin
                        // Beats past arlen without rlast: flag and keep waiting.
                        w_len_err_d = (r_beat_cnt == 9'd0);
                    end
                    w_beat_cnt_d = (r_beat_cnt == 9'd0) ? 9'd0 : r_beat_cnt - 9'd1;
                end
            end

            default: begin
                w_grant_d = 2'b00;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_beat_cnt   <= 9'd0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_grant <= w_last_grant_d;
            r_beat_cnt   <= w_beat_cnt_d;
            r_len_err    <= w_len_err_d;
        end
    end

    // ------------------------------------------------------------------
    // AR channel mux: only live in ADDR, all zeros otherwise
    // ------------------------------------------------------------------
    always_comb begin
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        m0_arready    = 1'b0;
        m1_arready    = 1'b0;

        if (r_state == ST_ADDR) begin
            if (r_grant[1]) begin
                s_axi_arid    = m1_arid;
                s_axi_araddr  = m1_araddr;
                s_axi_arlen   = m1_arlen;
                s_axi_arsize  = m1_arsize;
                s_axi_arburst = m1_arburst;
                s_axi_arvalid = m1_arvalid;
                m1_arready    = s_axi_arready;
            end else begin
                s_axi_arid    = m0_arid;
                s_axi_araddr  = m0_araddr;
                s_axi_arlen   = m0_arlen;
                s_axi_arsize  = m0_arsize;
                s_axi_arburst = m0_arburst;
                s_axi_arvalid = m0_arvalid;
                m0_arready    = s_axi_arready;
            end
        end
    end

    // ------------------------------------------------------------------
    // R channel steering: combinational, only in DATA. R beats arriving
    // outside DATA (e.g. left over after a reset) reach nobody.
    // ------------------------------------------------------------------
    always_comb begin
        m0_rid       = '0;
        m0_rdata     = '0;
        m0_rresp     = '0;
        m0_rlast     = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rid       = '0;
        m1_rdata     = '0;
        m1_rresp     = '0;
        m1_rlast     = 1'b0;
        m1_rvalid    = 1'b0;
        s_axi_rready = 1'b0;

        if (r_state == ST_DATA) begin
            if (r_grant[1]) begin
                m1_rid       = s_axi_rid;
                m1_rdata     = s_axi_rdata;
                m1_rresp     = s_axi_rresp;
                m1_rlast     = s_axi_rlast;
                m1_rvalid    = s_axi_rvalid;
                s_axi_rready = m1_rready;
            end else begin
                m0_rid       = s_axi_rid;
                m0_rdata     = s_axi_rdata;
                m0_rresp     = s_axi_rresp;
                m0_rlast     = s_axi_rlast;
                m0_rvalid    = s_axi_rvalid;
                s_axi_rready = m0_rready;
            end
        end
    end

    assign grant   = r_grant;
    assign busy    = (r_state != ST_IDLE);
    assign len_err = r_len_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Bench for axi_rd_arbiter. A small RAM model answers AR requests with
// beats whose data encodes {address[15:0], beat index}. Requester tasks push
// the expected beats into per-requester queues when they issue a burst. An
// independent monitor pops and compares on every R handshake, and also
// checks grant order against an expected-grant queue.
// ----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int unsigned DW = 256;
    localparam int unsigned IW = 4;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rsta_busy, rstb_busy;
    logic [IW-1:0] m0_arid, m1_arid;
    logic [AW-1:0] m0_araddr, m1_araddr;
    logic [7:0]    m0_arlen, m1_arlen;
    logic [2:0]    m0_arsize, m1_arsize;
    logic [1:0]    m0_arburst, m1_arburst;
    logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [IW-1:0] m0_rid, m1_rid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    m0_rresp, m1_rresp;
    logic          m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid, s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [1:0]    grant;
    logic          busy, len_err;

    int checks = 0;
    int errors = 0;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [1:0] exp_grant[$];
    int         len_err_seen = 0;
    int         ram_last_at  = -1;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .DATA_BIT_WIDTH (DW),
        .ID_WIDTH       (IW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rsta_busy     (rsta_busy),
        .rstb_busy     (rstb_busy),
        .m0_arid       (m0_arid),
        .m0_araddr     (m0_araddr),
        .m0_arlen      (m0_arlen),
        .m0_arsize     (m0_arsize),
        .m0_arburst    (m0_arburst),
        .m0_arvalid    (m0_arvalid),
        .m0_arready    (m0_arready),
        .m0_rid        (m0_rid),
        .m0_rdata      (m0_rdata),
        .m0_rresp      (m0_rresp),
        .m0_rlast      (m0_rlast),
        .m0_rvalid     (m0_rvalid),
        .m0_rready     (m0_rready),
        .m1_arid       (m1_arid),
        .m1_araddr     (m1_araddr),
        .m1_arlen      (m1_arlen),
        .m1_arsize     (m1_arsize),
        .m1_arburst    (m1_arburst),
        .m1_arvalid    (m1_arvalid),
        .m1_arready    (m1_arready),
        .m1_rid        (m1_rid),
        .m1_rdata      (m1_rdata),
        .m1_rresp      (m1_rresp),
        .m1_rlast      (m1_rlast),
        .m1_rvalid     (m1_rvalid),
        .m1_rready     (m1_rready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .grant         (grant),
        .busy          (busy),
        .len_err       (len_err)
    );

    // ---------------- RAM model ----------------
    logic          ram_active;
    logic [7:0]    ram_len;
    logic [8:0]    ram_beat;
    logic [15:0]   ram_addr;
    logic [IW-1:0] ram_id;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_active <= 1'b0;
            ram_len    <= '0;
            ram_beat   <= '0;
            ram_addr   <= '0;
            ram_id     <= '0;
        end else if (!ram_active && s_axi_arvalid && s_axi_arready) begin
            ram_active <= 1'b1;
            ram_len    <= s_axi_arlen;
            ram_addr   <= s_axi_araddr[15:0];
            ram_id     <= s_axi_arid;
            ram_beat   <= '0;
        end else if (ram_active && s_axi_rvalid && s_axi_rready) begin
            if (s_axi_rlast) ram_active <= 1'b0;
            else             ram_beat   <= ram_beat + 9'd1;
        end
    end

    assign s_axi_rvalid = ram_active;
    assign s_axi_rdata  = {232'd0, ram_addr, ram_beat[7:0]};
    assign s_axi_rid    = ram_id;
    assign s_axi_rresp  = ram_id[1:0];
    assign s_axi_rlast  = ram_active && ((ram_last_at >= 0) ? (int'(ram_beat) == ram_last_at)
                                                          : (ram_beat == {1'b0, ram_len}));

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] addr, input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {232'd0, addr[15:0], bb};
    endfunction

    // Issue one burst on requester req and push its expected beats.
    task automatic ar_req(input int req, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [IW-1:0] id, input int last_at);
        int    nb;
        int    n;
        bit    done;
        beat_t e;
        nb = (last_at < 0) ? int'(len) + 1 : last_at + 1;
        for (int b = 0; b < nb; b++) begin
            e.data = exp_data(addr, b);
            e.last = (b == nb - 1);
            e.id   = id;
            if (req == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        if (req == 0) begin
            m0_araddr = addr; m0_arlen = len; m0_arid = id; m0_arsize = 3'd5;
            m0_arburst = 2'b01; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arid = id; m1_arsize = 3'd5;
            m1_arburst = 2'b01; m1_arvalid = 1'b1;
        end
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            done = (req == 0) ? (m0_arvalid && m0_arready) : (m1_arvalid && m1_arready);
            n++;
        end
        check("ar_handshake_timeout", done, 1'b1);
        if (done) begin
            check("s_axi_araddr", s_axi_araddr, addr);
            check("s_axi_arlen", s_axi_arlen, len);
            check("s_axi_arid", s_axi_arid, id);
        end
        @(posedge clk); #1;
        if (req == 0) m0_arvalid = 1'b0;
        else          m1_arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, (q0.size() == 0 && q1.size() == 0), 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    beat_t      mon_e;
    logic [1:0] prev_grant   = 2'b00;
    logic       prev_len_err = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_grant   = 2'b00;
            prev_len_err = 1'b0;
        end else begin
            if (m0_rvalid && m0_rready) begin
                if (q0.size() == 0) begin
                    check("m0_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    mon_e = q0.pop_front();
                    check("m0_rdata", m0_rdata, mon_e.data);
                    check("m0_rlast", m0_rlast, mon_e.last);
                    check("m0_rid", m0_rid, mon_e.id);
                    check("m0_rresp", m0_rresp, mon_e.id[1:0]);
                end
            end
            if (m1_rvalid && m1_rready) begin
                if (q1.size() == 0) begin
                    check("m1_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    mon_e = q1.pop_front();
                    check("m1_rdata", m1_rdata, mon_e.data);
                    check("m1_rlast", m1_rlast, mon_e.last);
                    check("m1_rid", m1_rid, mon_e.id);
                    check("m1_rresp", m1_rresp, mon_e.id[1:0]);
                end
            end
            if (grant != 2'b01) check("m0_rvalid_not_granted", m0_rvalid, 1'b0);
            if (grant != 2'b10) begin
                check("m1_rvalid_not_granted", m1_rvalid, 1'b0);
                check("m1_rdata_not_granted", m1_rdata, '0);
            end
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (exp_grant.size() == 0) check("grant_unexpected", grant, 2'b00);
                else                       check("grant_order", grant, exp_grant.pop_front());
            end
            if (len_err) begin
                len_err_seen++;
                check("len_err_single_cycle", prev_len_err, 1'b0);
            end
            prev_grant   = grant;
            prev_len_err = len_err;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        rsta_busy = 1'b0; rstb_busy = 1'b0;
        m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
        m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_axi_arready = 1'b1;

        // Reset state with requests pending
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_s_arvalid", s_axi_arvalid, 1'b0);
        check("rst_s_rready", s_axi_rready, 1'b0);
        check("rst_m0_arready", m0_arready, 1'b0);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-requester burst: arvalid at t, grant/arvalid at t+1
        exp_grant.push_back(2'b01);
        @(posedge clk); #1;
        fork
            ar_req(0, 32'h40, 8'd3, 4'd1, -1);
            begin
                @(negedge clk);
                check("single_t0_s_arvalid", s_axi_arvalid, 1'b0);
                check("single_t0_grant", grant, 2'b00);
                @(negedge clk);
                check("single_t1_s_arvalid", s_axi_arvalid, 1'b1);
                check("single_t1_grant", grant, 2'b01);
            end
        join
        wait_drain("single_drain");
        @(negedge clk);
        check("single_end_busy", busy, 1'b0);
        check("single_end_grant", grant, 2'b00);

        // Contention after reset: m0, m1, m0, m1
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        fork
            begin
                ar_req(0, 32'h100, 8'd0, 4'd2, -1);
                ar_req(0, 32'h140, 8'd0, 4'd2, -1);
            end
            begin
                ar_req(1, 32'h180, 8'd0, 4'd3, -1);
                ar_req(1, 32'h1c0, 8'd0, 4'd3, -1);
            end
        join
        wait_drain("contention_drain");
        check("contention_grants_consumed", exp_grant.size(), 0);

        // Backpressure on m1
        exp_grant.push_back(2'b10);
        fork
            ar_req(1, 32'h200, 8'd7, 4'd7, -1);
            begin
                n = 0;
                while (n < 80 && !(n > 3 && q1.size() == 0)) begin
                    @(posedge clk); #1;
                    m1_rready = ~m1_rready;
                    @(negedge clk);
                    if (grant == 2'b10 && !s_axi_arvalid)
                        check("bp_s_rready_mirror", s_axi_rready, m1_rready);
                    n++;
                end
                m1_rready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        check("bp_no_len_err", len_err_seen, 0);

        // RAM busy gating
        exp_grant.push_back(2'b01);
        @(posedge clk); #1;
        rstb_busy = 1'b1;
        fork
            ar_req(0, 32'h300, 8'd1, 4'd4, -1);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("busy_hold_grant", grant, 2'b00);
                end
                @(posedge clk); #1;
                rstb_busy = 1'b0;
                @(negedge clk);
                check("busy_drop_t0_grant", grant, 2'b00);
                @(negedge clk);
                check("busy_drop_t1_grant", grant, 2'b01);
            end
        join
        wait_drain("busy_drain");

        // Length error: arlen=2, rlast on second beat
        ram_last_at = 1;
        exp_grant.push_back(2'b01);
        ar_req(0, 32'h400, 8'd2, 4'd6, 1);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = m0_rvalid && m0_rready && m0_rlast;
            n++;
        end
        check("lenerr_a_last_seen", seen, 1'b1);
        @(negedge clk);
        check("lenerr_a_pulse", len_err, 1'b1);
        check("lenerr_a_idle_busy", busy, 1'b0);
        check("lenerr_a_idle_grant", grant, 2'b00);
        @(negedge clk);
        check("lenerr_a_pulse_end", len_err, 1'b0);

        // Length error: arlen=0 but rlast only on second beat
        exp_grant.push_back(2'b01);
        ar_req(0, 32'h480, 8'd0, 4'd5, 1);
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = m0_rvalid && m0_rready && !m0_rlast;
            n++;
        end
        check("lenerr_b_beat0_seen", seen, 1'b1);
        @(negedge clk);
        check("lenerr_b_pulse", len_err, 1'b1);
        check("lenerr_b_still_busy", busy, 1'b1);
        wait_drain("lenerr_b_drain");
        ram_last_at = -1;
        @(negedge clk);
        check("lenerr_total", len_err_seen, 2);

        // Reset mid-burst (previous owner was m0, so reset must restore m0 priority)
        exp_grant.push_back(2'b01);
        @(posedge clk); #1;
        ar_req(0, 32'h500, 8'd5, 4'd8, -1);
        n = 0;
        while (q0.size() != 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_beat0_done", q0.size(), 5);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        check("rst_mid_grant", grant, 2'b00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_len_err", len_err, 1'b0);
        check("rst_mid_m0_rvalid", m0_rvalid, 1'b0);
        check("rst_mid_s_rready", s_axi_rready, 1'b0);
        check("rst_mid_s_arvalid", s_axi_arvalid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10);
        fork
            ar_req(0, 32'h600, 8'd0, 4'd9, -1);
            ar_req(1, 32'h640, 8'd0, 4'd10, -1);
        join
        wait_drain("post_rst_drain");

        repeat (3) @(negedge clk);
        check("final_grants_consumed", exp_grant.size(), 0);
        check("final_len_err_total", len_err_seen, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
